// File: rtl/synth_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : synth_ctrl_pkg                                               |
// | Description : Shared definitions for the synthesizer parameter loader:     |
// |               loader state encoding and payload field layout.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package synth_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_APPLY   = 2'd2,
    ST_START   = 2'd3
  } state_t;

  // Payload word layout (little-endian, P0 = W[7:0])
  localparam int TYPE_LSB      = 0;
  localparam int TYPE_W        = 2;
  localparam int FC_LSB        = 2;
  localparam int FC_W          = 32;
  localparam int TI_LSB        = 34;
  localparam int TI_W          = 10;
  localparam int TP_LSB        = 44;
  localparam int TP_W          = 13;
  localparam int NI_LSB        = 57;
  localparam int NI_W          = 5;
  localparam int DEV_LSB       = 62;
  localparam int DEV_W         = 22;
  localparam int PAYLOAD_BYTES = 11;
  localparam int PAYLOAD_BITS  = 8 * PAYLOAD_BYTES;
  // Bits that carry parameters; the top nibble of the payload is reserved.
  localparam int FIELD_BITS    = DEV_LSB + DEV_W;

endpackage
`default_nettype wire

// File: rtl/synth_frame_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : synth_frame_rx                                               |
// | Description : Frame body receiver. Shifts payload bytes into a shadow      |
// |               register, accumulates the XOR checksum, tracks the byte      |
// |               count and the inter-byte timeout.                            |
// | Ports       : i_clear     - sync byte accepted, start a new frame           |
// |               i_byte_en   - a frame byte (payload or checksum) accepted     |
// |               i_active    - loader is inside a frame (timeout runs)         |
// |               o_frame_good/o_frame_bad - single-cycle frame verdicts        |
// |               o_shadow    - received parameter bits                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module synth_frame_rx
  import synth_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            i_data,
  input  logic                  i_clear,
  input  logic                  i_byte_en,
  input  logic                  i_active,
  output logic                  o_frame_good,
  output logic                  o_frame_bad,
  output logic [FIELD_BITS-1:0] o_shadow
);

  localparam int              c_TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_TO_W-1:0] c_TO_MAX = c_TO_W'(TIMEOUT_CYCLES);

  logic [3:0]              r_cnt;
  logic [7:0]              r_xor;
  logic [PAYLOAD_BITS-1:0] r_shadow;
  logic [c_TO_W-1:0]       r_to_cnt;

  logic              w_csum_phase;
  logic [c_TO_W-1:0] w_to_inc;
  logic              w_timeout;

  // Once all payload bytes are in, the next accepted byte is the checksum.
  assign w_csum_phase = (r_cnt == 4'(PAYLOAD_BYTES));
  assign w_to_inc     = r_to_cnt + c_TO_W'(1);
  // Timeout fires on the edge where the idle count would reach the limit;
  // an accepted byte on that same edge wins.
  assign w_timeout    = i_active && !i_byte_en && (w_to_inc == c_TO_MAX);

  assign o_frame_good = i_byte_en && w_csum_phase && (i_data == r_xor);
  assign o_frame_bad  = (i_byte_en && w_csum_phase && (i_data != r_xor)) || w_timeout;
  assign o_shadow     = r_shadow[FIELD_BITS-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_xor    <= '0;
      r_shadow <= '0;
      r_to_cnt <= '0;
    end else if (i_clear) begin
      r_cnt    <= '0;
      r_xor    <= '0;
      r_to_cnt <= '0;
    end else if (i_byte_en) begin
      r_to_cnt <= '0;
      if (w_csum_phase) begin
        r_cnt <= '0;
      end else begin
        // New bytes enter at the top so P0 ends up in the low byte.
        r_shadow <= {i_data, r_shadow[PAYLOAD_BITS-1:8]};
        r_xor    <= r_xor ^ i_data;
        r_cnt    <= r_cnt + 4'd1;
      end
    end else if (i_active && (r_to_cnt != c_TO_MAX)) begin
      r_to_cnt <= w_to_inc;
    end
  end

endmodule
`default_nettype wire

// File: rtl/synth_param_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : synth_param_loader                                           |
// | Description : Host-side command frame loader for the synthesizer. Accepts  |
// |               SYNC + 11 payload bytes + XOR checksum, then atomically      |
// |               updates the parameter bus and optionally pulses the start.   |
// | Ports       : i_rx_data/i_rx_valid/o_rx_ready - byte stream handshake      |
// |               o_signal_type..o_deviation - parameter bus                   |
// |               o_sign_start_gen - generation start pulse                    |
// |               o_frame_ok/o_frame_err - frame status pulses                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module synth_param_loader
  import synth_ctrl_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_rx_ready,
  output logic [TYPE_W-1:0] o_signal_type,
  output logic [FC_W-1:0]   o_f_carrier,
  output logic [TI_W-1:0]   o_t_impulse,
  output logic [TP_W-1:0]   o_t_period,
  output logic [NI_W-1:0]   o_num_of_imp,
  output logic [DEV_W-1:0]  o_deviation,
  output logic              o_sign_start_gen,
  output logic              o_frame_ok,
  output logic              o_frame_err
);

  state_t r_state;
  state_t w_state_nxt;

  logic              r_rx_ready;
  logic [TYPE_W-1:0] r_signal_type;
  logic [FC_W-1:0]   r_f_carrier;
  logic [TI_W-1:0]   r_t_impulse;
  logic [TP_W-1:0]   r_t_period;
  logic [NI_W-1:0]   r_num_of_imp;
  logic [DEV_W-1:0]  r_deviation;
  logic              r_start;
  logic              r_frame_ok;
  logic              r_frame_err;

  logic                  w_accept;
  logic                  w_sync;
  logic                  w_byte_en;
  logic                  w_active;
  logic                  w_frame_good;
  logic                  w_frame_bad;
  logic                  w_rdy_nxt;
  logic [FIELD_BITS-1:0] w_shadow;

  assign w_accept  = i_rx_valid && r_rx_ready;
  assign w_sync    = (r_state == ST_IDLE) && w_accept && (i_rx_data == SYNC_BYTE);
  assign w_active  = (r_state == ST_PAYLOAD);
  assign w_byte_en = w_active && w_accept;

  synth_frame_rx #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_frame_rx (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_data       (i_rx_data),
    .i_clear      (w_sync),
    .i_byte_en    (w_byte_en),
    .i_active     (w_active),
    .o_frame_good (w_frame_good),
    .o_frame_bad  (w_frame_bad),
    .o_shadow     (w_shadow)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_sync) w_state_nxt = ST_PAYLOAD;
      ST_PAYLOAD: begin
        if (w_frame_good)     w_state_nxt = ST_APPLY;
        else if (w_frame_bad) w_state_nxt = ST_IDLE;
      end
      ST_APPLY:   w_state_nxt = AUTO_START ? ST_START : ST_IDLE;
      ST_START:   w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Ready is registered from the next state so it is low during reset and
  // glitch-free toward the byte source.
  assign w_rdy_nxt = (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_PAYLOAD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_ready    <= 1'b0;
      r_signal_type <= '0;
      r_f_carrier   <= '0;
      r_t_impulse   <= '0;
      r_t_period    <= '0;
      r_num_of_imp  <= '0;
      r_deviation   <= '0;
      r_start       <= 1'b0;
      r_frame_ok    <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_rx_ready  <= w_rdy_nxt;
      r_frame_ok  <= (r_state == ST_APPLY);
      // Start lags the parameter update by one cycle so the bus is settled.
      r_start     <= (r_state == ST_START);
      r_frame_err <= w_frame_bad;
      if (r_state == ST_APPLY) begin
        r_signal_type <= w_shadow[TYPE_LSB +: TYPE_W];
        r_f_carrier   <= w_shadow[FC_LSB   +: FC_W];
        r_t_impulse   <= w_shadow[TI_LSB   +: TI_W];
        r_t_period    <= w_shadow[TP_LSB   +: TP_W];
        r_num_of_imp  <= w_shadow[NI_LSB   +: NI_W];
        r_deviation   <= w_shadow[DEV_LSB  +: DEV_W];
      end
    end
  end

  assign o_rx_ready       = r_rx_ready;
  assign o_signal_type    = r_signal_type;
  assign o_f_carrier      = r_f_carrier;
  assign o_t_impulse      = r_t_impulse;
  assign o_t_period       = r_t_period;
  assign o_num_of_imp     = r_num_of_imp;
  assign o_deviation      = r_deviation;
  assign o_sign_start_gen = r_start;
  assign o_frame_ok       = r_frame_ok;
  assign o_frame_err      = r_frame_err;

endmodule
`default_nettype wire
